// File: rtl/simon_pkg.sv
// simon_pkg: shared state encoding, widths and LFSR step for the Simon sequencer
package simon_pkg;

    typedef enum logic [2:0] {IDLE, EXTEND, PLAY, GAP, WAIT_IN, FAIL, WIN} state_e;

    localparam int          COLOR_W   = 2;
    localparam int          IDX_W     = 6;
    localparam int          MEM_DEPTH = 64;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    function automatic logic [15:0] lfsr_next(input logic [15:0] q);
        return (q >> 1) ^ (q[0] ? LFSR_TAPS : 16'h0000);
    endfunction

endpackage

// File: rtl/adder_six.sv
// adder_six: 6-bit ripple-carry adder used for every level/step increment
module adder_six (
    input  logic [5:0] a,
    input  logic [5:0] b,
    output logic [5:0] sum
);
    logic [5:0] c;

    assign c[0] = 1'b0;

    for (genvar i = 0; i < 6; i++) begin : g_bit
        assign sum[i] = a[i] ^ b[i] ^ c[i];
        if (i < 5) begin : g_carry
            assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
    end

endmodule

// File: rtl/simon_lfsr16.sv
// simon_lfsr16: free-running 16-bit Galois LFSR, reloaded with seed on reset
module simon_lfsr16
    import simon_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] seed,
    output logic [15:0] q
);

    // advance one step every cycle, including while the game is idle
    always_ff @(posedge clk) begin
        q <= reset ? seed : lfsr_next(q);
    end

endmodule

// File: rtl/simon_sequencer.sv
// simon_sequencer: Simon round controller; optional press timeout via SIMON_INPUT_TIMEOUT_EN
module simon_sequencer
    import simon_pkg::*;
#(
    parameter int          MAX_LEVEL = 63,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
`ifdef SIMON_INPUT_TIMEOUT_EN
    , parameter int        TIMEOUT_TICKS = 8
`endif
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               tick,
    input  logic               btn_valid,
    input  logic [COLOR_W-1:0] btn_color,
    output logic               led_on,
    output logic [COLOR_W-1:0] led_color,
    output logic [IDX_W-1:0]   level,
    output logic               busy,
    output logic               game_over,
    output logic               win
);

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   level_q, level_d, idx_q, idx_d, level_inc, idx_inc;
    logic [COLOR_W-1:0] mem [MEM_DEPTH];
    logic [COLOR_W-1:0] lfsr_lo;
    logic [13:0]        lfsr_hi_unused;
    logic               hit, last_step;

    simon_lfsr16 u_lfsr (
        .clk   (clk),
        .reset (reset),
        .seed  (LFSR_SEED),
        .q     ({lfsr_hi_unused, lfsr_lo})
    );

    adder_six u_inc_level (.a(level_q), .b(6'd1), .sum(level_inc));
    adder_six u_inc_idx   (.a(idx_q),   .b(6'd1), .sum(idx_inc));

    assign hit       = btn_color == mem[idx_q];
    assign last_step = idx_inc == level_q;
    assign level     = level_q;
    assign busy      = state_q inside {EXTEND, PLAY, GAP, WAIT_IN};
    assign game_over = state_q == FAIL;
    assign win       = state_q == WIN;

`ifdef SIMON_INPUT_TIMEOUT_EN
    logic [3:0] tcnt_q, tcnt_d;
    logic       expired;

    assign expired = tick && (tcnt_q + 4'd1 == 4'(TIMEOUT_TICKS));

    // count ticks spent waiting for the current press; cleared outside WAIT_IN and on any press
    always_comb begin
        tcnt_d = (state_q != WAIT_IN || btn_valid) ? 4'd0 : tick ? tcnt_q + 4'd1 : tcnt_q;
    end

    // press-timeout counter register
    always_ff @(posedge clk) begin
        tcnt_q <= reset ? 4'd0 : tcnt_d;
    end
`endif

    // round sequencing, playback pacing and press checking
    always_comb begin
        state_d   = state_q;
        level_d   = level_q;
        idx_d     = idx_q;
        led_on    = 1'b0;
        led_color = '0;
        case (state_q)
            IDLE, FAIL, WIN: begin
                if (start) begin
                    state_d = EXTEND;
                    level_d = '0;
                end
            end
            EXTEND: begin
                level_d = level_inc;
                idx_d   = '0;
                state_d = PLAY;
            end
            PLAY: begin
                led_on    = 1'b1;
                led_color = mem[idx_q];
                if (tick) state_d = GAP;
            end
            GAP: begin
                if (tick) begin
                    idx_d   = last_step ? '0 : idx_inc;
                    state_d = last_step ? WAIT_IN : PLAY;
                end
            end
            WAIT_IN: begin
                led_on    = btn_valid;
                led_color = btn_color;
                if (btn_valid) begin
                    if (!hit) state_d = FAIL;
                    else if (idx_inc < level_q) idx_d = idx_inc;
                    else state_d = (level_q == IDX_W'(MAX_LEVEL)) ? WIN : EXTEND;
                end
`ifdef SIMON_INPUT_TIMEOUT_EN
                else if (expired) state_d = FAIL;
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    // control state registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            level_q <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            level_q <= level_d;
            idx_q   <= idx_d;
        end
    end

    // append the new random colour while extending; contents survive reset
    always_ff @(posedge clk) begin
        if (state_q == EXTEND) mem[level_q] <= lfsr_lo;
    end

endmodule

// File: tb/tb_simon_sequencer.sv
// tb_simon_sequencer: directed checks of the Simon sequencer (MAX_LEVEL=3) against an LFSR model
module tb_simon_sequencer;

    localparam int MAXL = 3;

    logic       clk = 1'b0, reset = 1'b1, start = 1'b0, tick = 1'b0, btn_valid = 1'b0;
    logic [1:0] btn_color = 2'd0;
    logic       led_on, busy, game_over, win;
    logic [1:0] led_color;
    logic [5:0] level;

    logic [15:0] m_lfsr;
    logic [1:0]  exp_mem [64];
    int          exp_level = 0;
    int          n_vec = 0, n_bad = 0;

    always #5 clk = ~clk;

    simon_sequencer #(.MAX_LEVEL(MAXL)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .tick      (tick),
        .btn_valid (btn_valid),
        .btn_color (btn_color),
        .led_on    (led_on),
        .led_color (led_color),
        .level     (level),
        .busy      (busy),
        .game_over (game_over),
        .win       (win)
    );

    always @(posedge clk)
        m_lfsr <= reset ? 16'hACE1 : ((m_lfsr >> 1) ^ (m_lfsr[0] ? 16'hB400 : 16'h0000));

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic status(input string tag, input logic lo, input logic [5:0] lv,
                          input logic b, input logic go, input logic w);
        check_eq({tag, ".led_on"}, 16'(led_on), 16'(lo));
        check_eq({tag, ".level"}, 16'(level), 16'(lv));
        check_eq({tag, ".busy"}, 16'(busy), 16'(b));
        check_eq({tag, ".game_over"}, 16'(game_over), 16'(go));
        check_eq({tag, ".win"}, 16'(win), 16'(w));
    endtask

    task automatic pulse_tick();
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
    endtask

    task automatic enter_extend();
        check_eq("extend.busy", 16'(busy), 16'd1);
        check_eq("extend.led_on", 16'(led_on), 16'd0);
        exp_mem[exp_level] = m_lfsr[1:0];
        exp_level++;
        @(negedge clk);
        check_eq("extend.level", 16'(level), 16'(exp_level));
        check_eq("extend.led_first", 16'(led_on), 16'd1);
    endtask

    task automatic do_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        exp_level = 0;
        enter_extend();
    endtask

    task automatic play();
        for (int i = 0; i < exp_level; i++) begin
            check_eq("play.led_on", 16'(led_on), 16'd1);
            check_eq("play.color", 16'(led_color), 16'(exp_mem[i]));
            pulse_tick();
            check_eq("gap.led_on", 16'(led_on), 16'd0);
            pulse_tick();
        end
        check_eq("wait.busy", 16'(busy), 16'd1);
        check_eq("wait.led_on", 16'(led_on), 16'd0);
    endtask

    task automatic press(input logic [1:0] c);
        btn_valid = 1'b1;
        btn_color = c;
        #1;
        check_eq("echo.led_on", 16'(led_on), 16'd1);
        check_eq("echo.color", 16'(led_color), 16'(c));
        @(negedge clk);
        btn_valid = 1'b0;
    endtask

    task automatic echo_all();
        for (int i = 0; i < exp_level; i++) press(exp_mem[i]);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge clk);
        reset = 1'b0;
        status("reset", 1'b0, 6'd0, 1'b0, 1'b0, 1'b0);

        do_start();
        check_eq("start.color", 16'(led_color), 16'(exp_mem[0]));
        btn_valid = 1'b1;
        btn_color = exp_mem[0] + 2'd1;
        @(negedge clk);
        btn_valid = 1'b0;
        status("play_btn_ignored", 1'b1, 6'd1, 1'b1, 1'b0, 1'b0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        status("play_start_ignored", 1'b1, 6'd1, 1'b1, 1'b0, 1'b0);
        play();
        echo_all();
        enter_extend();
        play();
        echo_all();
        enter_extend();
        play();
        press(exp_mem[0]);
        press(exp_mem[1] + 2'd1);
        status("wrong_press", 1'b0, 6'd3, 1'b0, 1'b1, 1'b0);
        pulse_tick();
        status("fail_hold", 1'b0, 6'd3, 1'b0, 1'b1, 1'b0);

        do_start();
        status("restart_from_fail", 1'b1, 6'd1, 1'b1, 1'b0, 1'b0);
        play();
        pulse_tick();
        check_eq("wait_tick.busy", 16'(busy), 16'd1);
        check_eq("wait_tick.game_over", 16'(game_over), 16'd0);
        echo_all();
        enter_extend();
        play();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        status("wait_start_ignored", 1'b0, 6'd2, 1'b1, 1'b0, 1'b0);
        echo_all();
        enter_extend();
        play();
        echo_all();
        status("win", 1'b0, 6'd3, 1'b0, 1'b0, 1'b1);
        pulse_tick();
        status("win_hold", 1'b0, 6'd3, 1'b0, 1'b0, 1'b1);

        do_start();
        status("restart_from_win", 1'b1, 6'd1, 1'b1, 1'b0, 1'b0);

`ifdef SIMON_INPUT_TIMEOUT_EN
        play();
        repeat (7) pulse_tick();
        status("timeout_7", 1'b0, 6'd1, 1'b1, 1'b0, 1'b0);
        tick = 1'b1;
        btn_valid = 1'b1;
        btn_color = exp_mem[0];
        @(negedge clk);
        tick = 1'b0;
        btn_valid = 1'b0;
        check_eq("press_beats_timeout.game_over", 16'(game_over), 16'd0);
        enter_extend();
        play();
        repeat (7) pulse_tick();
        check_eq("timeout_pre.game_over", 16'(game_over), 16'd0);
        pulse_tick();
        status("timeout", 1'b0, 6'd2, 1'b0, 1'b1, 1'b0);
        do_start();
`endif

        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        status("mid_reset", 1'b0, 6'd0, 1'b0, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
